// File: rtl/fft_stage_sequencer_if.sv
// Bundle of FFT stage sequencer signals: controller handshake, ping-pong RAM strobes/addresses, twiddle index.
// The master side is the sequencer; the slave side is the controller / RAM / twiddle ROM.
interface fft_stage_sequencer_if #(
    parameter int N             = 32,
    parameter int address_width = $clog2(N),
    parameter int stage_width   = $clog2($clog2(N))
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     bank_select;
    logic                     read_en;
    logic [address_width-1:0] rd_address1;
    logic [address_width-1:0] rd_address2;
    logic                     wr_en;
    logic [address_width-1:0] wr_address1;
    logic [address_width-1:0] wr_address2;
    logic [address_width-2:0] twiddle_index;
    logic [stage_width-1:0]   stage;
    logic                     result_bank;

    modport master (
        input  start,
        output busy, done, bank_select, read_en, rd_address1, rd_address2,
               wr_en, wr_address1, wr_address2, twiddle_index, stage, result_bank
    );

    modport slave (
        output start,
        input  busy, done, bank_select, read_en, rd_address1, rd_address2,
               wr_en, wr_address1, wr_address2, twiddle_index, stage, result_bank
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT stage sequencer: issues butterfly read pairs per stage, replays them as
// writes after the RAM + butterfly latency, and ping-pongs the banks between stages.
module fft_stage_sequencer #(
    parameter int N             = 32,
    parameter int address_width = $clog2(N),
    parameter int BF_LATENCY    = 3,
    parameter int RD_LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_stage_sequencer_if.master bus
);
    localparam int LOG2N = $clog2(N);
    localparam int SW    = $clog2(LOG2N);
    localparam int KW    = address_width - 1;
    localparam int D     = RD_LATENCY + BF_LATENCY;

    typedef logic [address_width-1:0] addr_t;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SWAP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            bank_q, bank_d;
    logic            result_q, result_d;
    logic            read_en_q, read_en_d;
    addr_t           rd1_q, rd1_d;
    addr_t           rd2_q, rd2_d;
    logic [KW-1:0]   tw_q, tw_d;
    logic            pipe_v_q  [D];
    logic            pipe_v_d  [D];
    addr_t           pipe_a1_q [D];
    addr_t           pipe_a1_d [D];
    addr_t           pipe_a2_q [D];
    addr_t           pipe_a2_d [D];
    logic            pending_s;

    function automatic addr_t pair_lo(input logic [KW-1:0] k, input logic [SW-1:0] s);
        addr_t kx;
        addr_t pos_mask;
        kx       = {1'b0, k};
        pos_mask = (addr_t'(1'b1) << s) - addr_t'(1'b1);
        return ((kx >> s) << (32'(s) + 32'd1)) | (kx & pos_mask);
    endfunction

    function automatic logic [KW-1:0] twiddle_of(input logic [KW-1:0] k, input logic [SW-1:0] s);
        logic [KW-1:0] pos_mask;
        pos_mask = (KW'(1'b1) << s) - KW'(1'b1);
        return (k & pos_mask) << (LOG2N - 1 - 32'(s));
    endfunction

    // Next-state, counters and read-side outputs; the delay line shifts every cycle.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        stage_d   = stage_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bank_d    = bank_q;
        result_d  = result_q;
        read_en_d = 1'b0;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        tw_d      = tw_q;

        pending_s = 1'b0;
        for (int i = 0; i < D - 1; i++) begin
            pending_s = pending_s | pipe_v_q[i];
        end

        pipe_v_d[0]  = read_en_q;
        pipe_a1_d[0] = rd1_q;
        pipe_a2_d[0] = rd2_q;
        for (int i = 1; i < D; i++) begin
            pipe_v_d[i]  = pipe_v_q[i-1];
            pipe_a1_d[i] = pipe_a1_q[i-1];
            pipe_a2_d[i] = pipe_a2_q[i-1];
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_READ;
                    busy_d    = 1'b1;
                    stage_d   = SW'(1'b0);
                    k_d       = KW'(1'b0);
                    bank_d    = 1'b0;
                    read_en_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (k_q == KW'(N / 2 - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d       = k_q + KW'(1'b1);
                    read_en_d = 1'b1;
                end
            end
            // Leave once only the final write remains, so it lands in the last DRAIN cycle.
            ST_DRAIN: begin
                if (!pending_s) begin
                    state_d = ST_SWAP;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_SWAP: begin
                bank_d = ~bank_q;
                if (stage_q == SW'(LOG2N - 1)) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = bank_q;
                end else begin
                    state_d   = ST_READ;
                    stage_d   = stage_q + SW'(1'b1);
                    k_d       = KW'(1'b0);
                    read_en_d = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (read_en_d) begin
            rd1_d = pair_lo(k_d, stage_d);
            rd2_d = rd1_d + (addr_t'(1'b1) << stage_d);
            tw_d  = twiddle_of(k_d, stage_d);
        end else begin
            rd1_d = rd1_q;
            rd2_d = rd2_q;
            tw_d  = tw_q;
        end
    end

    // State and output registers; async reset also flushes pending writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            k_q       <= KW'(1'b0);
            stage_q   <= SW'(1'b0);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bank_q    <= 1'b0;
            result_q  <= 1'b0;
            read_en_q <= 1'b0;
            rd1_q     <= addr_t'(1'b0);
            rd2_q     <= addr_t'(1'b0);
            tw_q      <= KW'(1'b0);
            for (int i = 0; i < D; i++) begin
                pipe_v_q[i]  <= 1'b0;
                pipe_a1_q[i] <= addr_t'(1'b0);
                pipe_a2_q[i] <= addr_t'(1'b0);
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            stage_q   <= stage_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bank_q    <= bank_d;
            result_q  <= result_d;
            read_en_q <= read_en_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            tw_q      <= tw_d;
            for (int i = 0; i < D; i++) begin
                pipe_v_q[i]  <= pipe_v_d[i];
                pipe_a1_q[i] <= pipe_a1_d[i];
                pipe_a2_q[i] <= pipe_a2_d[i];
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.bank_select   = bank_q;
    assign bus.read_en       = read_en_q;
    assign bus.rd_address1   = rd1_q;
    assign bus.rd_address2   = rd2_q;
    assign bus.twiddle_index = tw_q;
    assign bus.stage         = stage_q;
    assign bus.result_bank   = result_q;
    assign bus.wr_en         = pipe_v_q[D-1];
    assign bus.wr_address1   = pipe_a1_q[D-1];
    assign bus.wr_address2   = pipe_a2_q[D-1];
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Drives the dual-bank ping-pong complex RAM interface for an in-place radix-2 DIT FFT.
- Each stage: issues butterfly read address pairs to the read bank, re-issues the same pairs as write addresses to the write bank once the butterfly pipeline returns results, then flips `bank_select`.
- Sits between the top-level FFT controller (`start`/`done`) and the RAM interface plus twiddle ROM.

Parameters:
- `N`, 32, FFT length; power of two, N ≥ 4.
- `address_width`, $clog2(N), RAM address width.
- `BF_LATENCY`, 3, cycles from RAM sample output to butterfly result at `comp1`/`comp2`.
- `RD_LATENCY`, 1, RAM read latency from `read_en` to sample output.

Ports:
- `clk` input 1 — rising-edge clock.
- `reset` input 1 — asynchronous, active-low reset.
- `start` input 1 — begin a full FFT; sampled only in IDLE.
- `busy` output 1 — high from start acceptance until `done`.
- `done` output 1 — one-cycle pulse after the final stage.
- `bank_select` output 1 — 0: bank0 written, bank1 read; 1: the reverse.
- `read_en` output 1 — read strobe to the RAM interface.
- `rd_address1`, `rd_address2` output address_width — butterfly read pair.
- `wr_en` output 1 — write strobe to the RAM interface.
- `wr_address1`, `wr_address2` output address_width — butterfly write pair.
- `twiddle_index` output address_width-1 — twiddle ROM index, aligned with `read_en`.
- `stage` output $clog2($clog2(N)) — current stage number.
- `result_bank` output 1 — bank holding the final result; valid when `done` pulses.

Behaviour:
- Reset (async, `reset`=0): state IDLE. All outputs 0: `busy`, `done`, `bank_select`, `read_en`, `wr_en`, addresses, `twiddle_index`, `stage`, `result_bank`. Delay line cleared.
- Input samples are preloaded in bank1, so the first stage runs with `bank_select`=0.
- FSM states: IDLE, READ, DRAIN, SWAP, DONE.
- IDLE → READ on `start`=1. At that edge: `busy`←1, `stage`←0, k←0, `bank_select`←0.
- READ:
  - `read_en`=1 every cycle; butterfly index k runs 0..N/2-1.
  - Let span = 1<<stage, pos = k & (span-1), grp = k >> stage.
  - `rd_address1` = (grp << (stage+1)) | pos; `rd_address2` = `rd_address1` + span.
  - `twiddle_index` = pos << (log2N-1-stage).
  - After k=N/2-1 → DRAIN.
- Write pipeline:
  - Read address pair plus valid bit pass through a shift register of depth D = RD_LATENCY + BF_LATENCY.
  - `wr_en` and `wr_address1`/`wr_address2` equal the read-side values exactly D cycles earlier.
  - Writes occur in READ, DRAIN, and never outside them.
- DRAIN: `read_en`=0. Stays until the delay line holds no valid entry and the last write has been issued, i.e. D cycles after the last read, then → SWAP.
- SWAP: one cycle, `read_en`=`wr_en`=0.
  - `bank_select` toggles at the exit edge.
  - If `stage`=log2N-1 → DONE; else `stage`++, k←0, → READ.
  - `bank_select` is constant from the first read to the last write of a stage; the RAM interface registers `bank_select` for output routing.
- DONE: one cycle. `done`=1; `busy`←0 at exit. `result_bank` = bank written in the final stage = ~`bank_select` (post-toggle value). Then → IDLE.
- Cycle budget per stage: N/2 + D + 1 cycles (N=32, D=4: 16 READ + 4 DRAIN + 1 SWAP = 21).
- `start` while `busy`: ignored. `start` held high through DONE: new run accepted on the IDLE cycle after `done`.
- Reset mid-run: immediate return to IDLE. Pending delay-line writes are discarded and `wr_en` drops asynchronously.
- Address arithmetic is unsigned, width address_width; `rd_address2` never wraps (max N-1).

Test Plan:
- Reset: assert `reset`=0 mid-READ (N=32) → `read_en`, `wr_en`, `busy`, `bank_select` all 0 immediately; `start` after release runs a clean full FFT.
- Stage 0 addressing: `start` pulse → first read cycles give pairs (0,1),(2,3),…,(30,31); `twiddle_index`=0 throughout; `bank_select`=0.
- Stage 1 and final-stage addressing:
  - Stage 1: k=1 → (1,3), twiddle 8; k=2 → (4,6), twiddle 0.
  - Stage 4: k=0 → (0,16), k=15 → (15,31), twiddle 15.
- Write alignment: each `wr_en` pulse occurs exactly 4 cycles after the matching `read_en`, with identical addresses. 16 writes per stage. No write overlaps a SWAP cycle.
- Timing and banking, N=32:
  - `done` pulses exactly 105 cycles after the start-accept edge.
  - `bank_select` sequence per stage is 0,1,0,1,0.
  - `result_bank`=0 at `done`.
  - `busy`=0 the cycle after `done`.
- Control edge cases:
  - `start` re-pulsed during stage 2 → ignored, cycle count unchanged.
  - `start` held high continuously → second run begins one cycle after `done`.
